// File: rtl/weyl_bitstream_serializer.sv
// Serializes one BITSTREAM-bit Weyl word into LANES-bit beats, LSB first, with valid/ready on both sides.
// Optional popcount/quota check is compiled in with `define WEYL_SER_POPCNT_EN.
module weyl_bitstream_serializer #(
  parameter int BITSTREAM = 64,
  parameter int LANES     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BITSTREAM-1:0]         in_stream,
  input  logic [$clog2(BITSTREAM)-1:0] in_quota,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0]             out_bits,
  output logic                         out_first,
  output logic                         out_last,
  output logic                         busy
`ifdef WEYL_SER_POPCNT_EN
  ,
  output logic [$clog2(BITSTREAM):0]   ones_cnt,
  output logic                         quota_err
`endif
);

  // state | meaning
  // IDLE  | no word held, ready for a new word
  // SEND  | word held, beat_q selects the beat on out_bits
  typedef enum logic {IDLE, SEND} state_t;

  localparam int BEATS = BITSTREAM / LANES;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int QW    = $clog2(BITSTREAM);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  state_t               state_q, state_d;
  logic [BITSTREAM-1:0] word_q;
  logic [BCW-1:0]       beat_q;
  logic [LANES-1:0]     beat_bits;
  logic                 at_last, fire_out, load;

  assign beat_bits = word_q[beat_q*LANES +: LANES];
  assign at_last   = (beat_q == LAST_BEAT);
  assign out_valid = (state_q == SEND);
  assign busy      = out_valid;
  // Idle outputs are forced low so the beat counter parked at the last beat is not visible.
  assign out_bits  = out_valid ? beat_bits : '0;
  assign out_first = out_valid & (beat_q == '0);
  assign out_last  = out_valid & at_last;
  assign fire_out  = out_valid & out_ready;
  assign in_ready  = (state_q == IDLE) | (fire_out & at_last);
  assign load      = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load) state_d = SEND;
      SEND: if (fire_out && at_last) state_d = in_valid ? SEND : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        word_q <= in_stream;
        beat_q <= '0;
      end else if (fire_out && !at_last) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

`ifdef WEYL_SER_POPCNT_EN
  logic [QW-1:0] quota_q;
  logic [QW:0]   ones_q, beat_pop, ones_total;
  logic          quota_err_q;

  always_comb begin
    beat_pop = '0;
    for (int j = 0; j < LANES; j++) beat_pop = beat_pop + (QW+1)'(beat_bits[j]);
  end

  assign ones_total = ones_q + beat_pop;
  assign ones_cnt   = ones_q;
  assign quota_err  = quota_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      quota_q     <= '0;
      ones_q      <= '0;
      quota_err_q <= 1'b0;
    end else begin
      quota_err_q <= fire_out & at_last & (ones_total != {1'b0, quota_q});
      if (load) begin
        quota_q <= in_quota;
        ones_q  <= '0;
      end else if (fire_out) begin
        ones_q <= ones_total;
      end
    end
  end
`else
  logic unused_quota;
  assign unused_quota = ^in_quota;
`endif

endmodule

// File: tb/tb_weyl_bitstream_serializer.sv
// Directed bench for weyl_bitstream_serializer: LANES=1 instance (a_*) and LANES=8 instance (b_*).
module tb_weyl_bitstream_serializer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_first, a_out_last, a_busy;
  logic [63:0] a_in_stream;
  logic [5:0]  a_in_quota;
  logic [0:0]  a_out_bits;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_first, b_out_last, b_busy;
  logic [63:0] b_in_stream;
  logic [5:0]  b_in_quota;
  logic [7:0]  b_out_bits;
`ifdef WEYL_SER_POPCNT_EN
  logic [6:0]  a_ones_cnt, b_ones_cnt;
  logic        a_quota_err, b_quota_err;
`endif

  weyl_bitstream_serializer #(.BITSTREAM(64), .LANES(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_stream(a_in_stream), .in_quota(a_in_quota), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_bits(a_out_bits), .out_first(a_out_first),
    .out_last(a_out_last), .busy(a_busy)
`ifdef WEYL_SER_POPCNT_EN
    , .ones_cnt(a_ones_cnt), .quota_err(a_quota_err)
`endif
  );

  weyl_bitstream_serializer #(.BITSTREAM(64), .LANES(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_stream(b_in_stream), .in_quota(b_in_quota), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_bits(b_out_bits), .out_first(b_out_first),
    .out_last(b_out_last), .busy(b_busy)
`ifdef WEYL_SER_POPCNT_EN
    , .ones_cnt(b_ones_cnt), .quota_err(b_quota_err)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [127:0] seen, fmask, lmask;
  int           vcnt, stable, ones;
  logic         rdy63;
  logic         qe64;

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_stream = '0; a_in_quota = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_stream = '0; b_in_quota = '0; b_out_ready = 1;
    qe64 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state
    chk("rst_out_valid", 128'(a_out_valid), 128'd0);
    chk("rst_out_bits",  128'(a_out_bits),  128'd0);
    chk("rst_first_last", 128'({a_out_first, a_out_last}), 128'd0);
    chk("rst_busy",      128'(a_busy),      128'd0);
    chk("rst_in_ready",  128'(a_in_ready),  128'd1);
    chk("rst_b_valid",   128'(b_out_valid), 128'd0);
`ifdef WEYL_SER_POPCNT_EN
    chk("rst_ones_cnt",  128'(a_ones_cnt),  128'd0);
    chk("rst_quota_err", 128'(a_quota_err), 128'd0);
`endif

    // single word, one bit at position 61
    rst = 0;
    a_in_valid = 1; a_in_stream = 64'h1 << 61; a_in_quota = 6'd1;
    tick();
    a_in_valid = 0;
    seen = '0; fmask = '0; lmask = '0; vcnt = 0;
    for (int k = 0; k < 64; k++) begin
      seen[k] = a_out_bits[0]; fmask[k] = a_out_first; lmask[k] = a_out_last;
      if (a_out_valid) vcnt++;
      tick();
    end
    chk("t1_bits",  seen,  128'h2000_0000_0000_0000);
    chk("t1_first", fmask, 128'h1);
    chk("t1_last",  lmask, 128'h8000_0000_0000_0000);
    chk("t1_valid_beats", 128'(vcnt), 128'd64);
    chk("t1_idle_after", 128'({a_out_valid, a_busy, a_in_ready}), 128'b001);
`ifdef WEYL_SER_POPCNT_EN
    chk("t1_ones_cnt",  128'(a_ones_cnt),  128'd1);
    chk("t1_quota_err", 128'(a_quota_err), 128'd0);
`endif

    // back-to-back: all-ones word then zero word, in_valid held
    a_in_valid = 1; a_in_stream = '1; a_in_quota = 6'd0;
    tick();
    a_in_stream = '0;
    seen = '0; fmask = '0; lmask = '0; vcnt = 0; rdy63 = 0;
    for (int k = 0; k < 128; k++) begin
      seen[k] = a_out_bits[0]; fmask[k] = a_out_first; lmask[k] = a_out_last;
      if (a_out_valid) vcnt++;
      if (k == 63) rdy63 = a_in_ready;
`ifdef WEYL_SER_POPCNT_EN
      if (k == 64) qe64 = a_quota_err;
`endif
      if (k == 64) a_in_valid = 0;
      tick();
    end
    chk("t2_bits",  seen,  {64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
    chk("t2_first", fmask, {64'h1, 64'h1});
    chk("t2_last",  lmask, {64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000});
    chk("t2_no_bubble", 128'(vcnt), 128'd128);
    chk("t2_ready_last", 128'(rdy63), 128'd1);
    chk("t2_idle_after", 128'(a_out_valid), 128'd0);
`ifdef WEYL_SER_POPCNT_EN
    chk("t2_quota_err_a", 128'(qe64), 128'd1);
    chk("t2_ones_cnt_b",  128'(a_ones_cnt), 128'd0);
    chk("t2_quota_err_b", 128'(a_quota_err), 128'd0);
`endif

    // backpressure at beat 10
    a_in_valid = 1; a_in_stream = (64'h1 << 63) | (64'h1 << 10); a_in_quota = 6'd2;
    tick();
    a_in_valid = 0;
    for (int k = 0; k < 10; k++) tick();
    chk("t3_beat10_bit", 128'(a_out_bits), 128'd1);
    a_out_ready = 0;
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (a_out_valid && a_out_bits == 1'b1 && !a_out_first && !a_out_last && !a_in_ready) stable++;
    end
    chk("t3_frozen_cycles", 128'(stable), 128'd5);
    a_out_ready = 1;
    vcnt = 0; ones = 0;
    for (int i = 0; i < 100 && a_out_valid; i++) begin
      vcnt++;
      ones += int'(a_out_bits[0]);
      tick();
    end
    chk("t3_remaining_beats", 128'(vcnt), 128'd54);
    chk("t3_remaining_ones",  128'(ones), 128'd2);
    chk("t3_drained", 128'(a_out_valid), 128'd0);

    // reset mid-word at beat 30
    a_in_valid = 1; a_in_stream = '1;
    tick();
    a_in_valid = 0;
    for (int k = 0; k < 30; k++) tick();
    chk("t4_busy_beat30", 128'(a_out_valid), 128'd1);
    rst = 1;
    tick();
    chk("t4_after_rst", 128'({a_out_valid, a_in_ready, a_busy, a_out_bits}), 128'b0100);
    rst = 0;
    tick();
    chk("t4_no_more_beats", 128'(a_out_valid), 128'd0);
    a_in_valid = 1; a_in_stream = 64'h1;
    tick();
    a_in_valid = 0;
    chk("t4_restart_beat0", 128'({a_out_valid, a_out_first, a_out_last, a_out_bits}), 128'b1101);
    for (int k = 0; k < 64; k++) tick();
    chk("t4_drained", 128'(a_out_valid), 128'd0);

    // LANES=8 instance
    b_in_valid = 1; b_in_stream = 64'h00FF_0000_0000_00A5; b_in_quota = 6'd12;
    tick();
    b_in_valid = 0;
    seen = '0; fmask = '0; lmask = '0;
    for (int k = 0; k < 8; k++) begin
      seen[k*8 +: 8] = b_out_bits; fmask[k] = b_out_first; lmask[k] = b_out_last;
      tick();
    end
    chk("t5_beats", seen,  128'h00FF_0000_0000_00A5);
    chk("t5_first", fmask, 128'h01);
    chk("t5_last",  lmask, 128'h80);
    chk("t5_drained", 128'(b_out_valid), 128'd0);
`ifdef WEYL_SER_POPCNT_EN
    chk("t5_ones_cnt",  128'(b_ones_cnt),  128'd12);
    chk("t5_quota_err", 128'(b_quota_err), 128'd0);

    // five ones against quota 4, then against quota 5
    a_in_valid = 1; a_in_stream = 64'h8000_0001_0010_0101; a_in_quota = 6'd4;
    tick();
    a_in_valid = 0;
    for (int k = 0; k < 64; k++) tick();
    chk("t6_ones_cnt",   128'(a_ones_cnt),  128'd5);
    chk("t6_err_pulse",  128'(a_quota_err), 128'd1);
    tick();
    chk("t6_err_cleared", 128'(a_quota_err), 128'd0);
    chk("t6_ones_held",   128'(a_ones_cnt),  128'd5);
    a_in_valid = 1; a_in_quota = 6'd5;
    tick();
    a_in_valid = 0;
    for (int k = 0; k < 64; k++) tick();
    chk("t6_ok_ones",  128'(a_ones_cnt),  128'd5);
    chk("t6_ok_noerr", 128'(a_quota_err), 128'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
